// File: rtl/sa_feeder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sa_pkg
//  Description : Shared definitions for the systolic-array feed stage.
//                Holds the default lane geometry, the feeder state encoding
//                and a helper that extracts one lane from a packed vector.
//  Revision    : 1.0  initial release
// ============================================================================
package sa_pkg;

    localparam int C_LANES_DEF = 4;
    localparam int C_WIDTH_DEF = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2,
        DONE   = 2'd3
    } feeder_state_t;

    // Lane i of a packed vector of default geometry lives at [i*WIDTH +: WIDTH].
    function automatic logic [C_WIDTH_DEF-1:0] lane_slice(
        input logic [C_LANES_DEF*C_WIDTH_DEF-1:0] vec,
        input int unsigned                        lane
    );
        return vec[lane*C_WIDTH_DEF +: C_WIDTH_DEF];
    endfunction

endpackage
`default_nettype wire

// File: rtl/sa_feeder_if.sv
`default_nettype none
// ============================================================================
//  Module      : sa_feeder_if
//  Description : Upstream valid/ready vector stream into the feeder.
//                master : producer (drives s_vld, s_data, s_last)
//                slave  : feeder   (drives s_rdy)
//  Ports       : none (signals only)
//  Revision    : 1.0  initial release
// ============================================================================
interface sa_feeder_if
    import sa_pkg::*;
#(
    parameter int LANES = C_LANES_DEF,
    parameter int WIDTH = C_WIDTH_DEF
) ();

    logic                   s_vld;
    logic                   s_rdy;
    logic [LANES*WIDTH-1:0] s_data;
    logic                   s_last;

    modport master (
        output s_vld,
        output s_data,
        output s_last,
        input  s_rdy
    );

    modport slave (
        input  s_vld,
        input  s_data,
        input  s_last,
        output s_rdy
    );

endinterface
`default_nettype wire

// File: rtl/sa_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : sa_feeder
//  Description : Upstream feed stage of the systolic array. Registers accepted
//                operand vectors onto the per-lane outputs, then injects
//                FLUSH_LEN zero beats so the skewed array drains, then pulses
//                o_done for one cycle.
//  Ports       : clk, rst      - clock, synchronous active-high reset
//                s (slave)     - upstream vector stream (s_vld/s_rdy/s_data/s_last)
//                o_vld         - beat valid to the lane delay lines
//                o_data        - lane data, lane i at [i*WIDTH +: WIDTH]
//                o_first       - first vector of operand
//                o_last        - last real vector of operand
//                o_done        - one-cycle pulse once the flush has completed
//                o_err         - sticky MAX_K overrun flag
//                o_beat_cnt    - beat counter, only with SA_FEEDER_BEAT_CNT_EN
//  Options     : SA_FEEDER_BEAT_CNT_EN adds the saturating 32-bit beat counter.
//  Revision    : 1.0  initial release
// ============================================================================
module sa_feeder
    import sa_pkg::*;
#(
    parameter int LANES     = C_LANES_DEF,
    parameter int WIDTH     = C_WIDTH_DEF,
    parameter int MAX_K     = 64,
    parameter int FLUSH_LEN = 2*LANES-2
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    sa_feeder_if.slave                  s,
    output logic                        o_vld,
    output logic [LANES*WIDTH-1:0]      o_data,
    output logic                        o_first,
    output logic                        o_last,
    output logic                        o_done,
    output logic                        o_err
`ifdef SA_FEEDER_BEAT_CNT_EN
    ,
    output logic [31:0]                 o_beat_cnt
`endif
);

    localparam int C_KW = $clog2(MAX_K + 1);
    localparam int C_FW = $clog2(FLUSH_LEN + 1);

    feeder_state_t            r_state, w_state_nxt;
    logic                     r_rdy, w_rdy_nxt;
    logic                     r_vld, w_vld_nxt;
    logic [LANES*WIDTH-1:0]   r_data, w_data_nxt;
    logic                     r_first, w_first_nxt;
    logic                     r_last, w_last_nxt;
    logic                     r_done, w_done_nxt;
    logic                     r_err, w_err_nxt;
    logic [C_KW-1:0]          r_k_cnt, w_k_cnt_nxt;
    logic [C_FW-1:0]          r_flush_cnt, w_flush_cnt_nxt;

    logic                     w_accept;
    logic [C_KW-1:0]          w_k_inc;
    logic                     w_hit_max;
    logic                     w_end;
    logic                     w_overrun;

    // s_rdy is held low in DONE and FLUSH, so accepts only happen in IDLE/STREAM.
    assign w_accept  = s.s_vld & r_rdy;
    assign w_k_inc   = (r_state == IDLE) ? C_KW'(1) : (r_k_cnt + C_KW'(1));
    assign w_hit_max = (w_k_inc == C_KW'(MAX_K));
    assign w_end     = s.s_last | w_hit_max;
    assign w_overrun = w_hit_max & ~s.s_last;

    always_comb begin
        w_state_nxt     = r_state;
        w_vld_nxt       = 1'b0;
        w_data_nxt      = r_data;
        w_first_nxt     = 1'b0;
        w_last_nxt      = 1'b0;
        w_done_nxt      = 1'b0;
        w_err_nxt       = r_err;
        w_k_cnt_nxt     = r_k_cnt;
        w_flush_cnt_nxt = r_flush_cnt;

        unique case (r_state)
            IDLE, STREAM: begin
                if (w_accept) begin
                    w_vld_nxt   = 1'b1;
                    w_data_nxt  = s.s_data;
                    w_first_nxt = (r_state == IDLE);
                    w_k_cnt_nxt = w_k_inc;
                    if (w_end) begin
                        w_last_nxt      = 1'b1;
                        w_state_nxt     = FLUSH;
                        w_flush_cnt_nxt = '0;
                    end else begin
                        w_state_nxt = STREAM;
                    end
                    if (w_overrun) begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            FLUSH: begin
                // flush_cnt counts zero beats already emitted; once all of them
                // are out, this edge raises done instead of another beat.
                if (r_flush_cnt == C_FW'(FLUSH_LEN)) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = DONE;
                end else begin
                    w_vld_nxt       = 1'b1;
                    w_data_nxt      = '0;
                    w_flush_cnt_nxt = r_flush_cnt + C_FW'(1);
                end
            end
            DONE: begin
                w_state_nxt     = IDLE;
                w_k_cnt_nxt     = '0;
                w_flush_cnt_nxt = '0;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // Registered from the next state so s_rdy never depends on s_vld.
        w_rdy_nxt = (w_state_nxt == IDLE) || (w_state_nxt == STREAM);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_rdy       <= 1'b0;
            r_vld       <= 1'b0;
            r_data      <= '0;
            r_first     <= 1'b0;
            r_last      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_k_cnt     <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_rdy       <= w_rdy_nxt;
            r_vld       <= w_vld_nxt;
            r_data      <= w_data_nxt;
            r_first     <= w_first_nxt;
            r_last      <= w_last_nxt;
            r_done      <= w_done_nxt;
            r_err       <= w_err_nxt;
            r_k_cnt     <= w_k_cnt_nxt;
            r_flush_cnt <= w_flush_cnt_nxt;
        end
    end

    assign s.s_rdy = r_rdy;
    assign o_vld   = r_vld;
    assign o_data  = r_data;
    assign o_first = r_first;
    assign o_last  = r_last;
    assign o_done  = r_done;
    assign o_err   = r_err;

`ifdef SA_FEEDER_BEAT_CNT_EN
    logic [31:0] r_beat_cnt;

    // Advances on the same edge that raises o_vld, so it already includes the
    // beat currently on the outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_beat_cnt <= '0;
        end else if (w_vld_nxt && (r_beat_cnt != '1)) begin
            r_beat_cnt <= r_beat_cnt + 32'd1;
        end
    end

    assign o_beat_cnt = r_beat_cnt;
`endif

endmodule
`default_nettype wire
